// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and mode type.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SEXT   = 2'd0;
    localparam logic [1:0] MODE_ZEXT   = 2'd1;
    localparam logic [1:0] MODE_LUI    = 2'd2;
    localparam logic [1:0] MODE_BRANCH = 2'd3;

    typedef enum logic [1:0] {
        ModeSext   = 2'd0,
        ModeZext   = 2'd1,
        ModeLui    = 2'd2,
        ModeBranch = 2'd3
    } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, upper-load and branch-offset modes.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] lui;
    logic [OUT_W-1:0] branch;

    // Size casts avoid zero-width replications when IN_W equals OUT_W.
    assign sext   = OUT_W'($signed(imm));
    assign zext   = OUT_W'(imm);
    // Shifting by the full width yields zero, which is the required truncation.
    assign lui    = zext << IN_W;
    assign branch = sext << 2;

    always_comb begin
        ext = sext;
        case (mode)
            MODE_SEXT:   ext = sext;
            MODE_ZEXT:   ext = zext;
            MODE_LUI:    ext = lui;
            MODE_BRANCH: ext = branch;
            default:     ext = sext;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// Pipelined immediate-extension stage with valid/ready handshake and a one-entry skid
// behind the output register, so downstream stalls never drop an accepted immediate.
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic [OUT_W-1:0] in_ext;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;
    logic             skid_full_q, skid_full_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;

    logic in_fire;
    logic out_free;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .ext  (in_ext)
    );

    assign in_ready = ~skid_full_q;
    assign in_fire  = in_valid & in_ready;
    // Output register may be overwritten when empty or retiring this cycle.
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;

        if (out_free) begin
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_data_d  = skid_data_q;
                out_tag_d   = skid_tag_q;
                skid_full_d = 1'b0;
                // Older entry goes out first; any concurrent beat waits in the skid.
                if (in_fire) begin
                    skid_full_d = 1'b1;
                    skid_data_d = in_ext;
                    skid_tag_d  = in_tag;
                end
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = in_ext;
                out_tag_d   = in_tag;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_full_d = 1'b1;
            skid_data_d = in_ext;
            skid_tag_d  = in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule
